vdp_ctrl_port: RTL and testbench



---
 rtl/vdp_pkg.sv | 24 ++
 rtl/vdp_ctrl_port_if.sv | 31 +++
 rtl/vdp_reg_bank.sv | 27 ++
 rtl/vdp_ctrl_port.sv | 146 ++++++++++++++
 tb/tb_vdp_ctrl_port.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/vdp_pkg.sv
// Shared types and default constants for the VDP control/data port engine.
package vdp_pkg;

    typedef enum logic [1:0] {
        VRAM_RD = 2'd0,
        VRAM_WR = 2'd1,
        REG_WR  = 2'd2,
        CRAM_WR = 2'd3
    } code_e;

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StHold
    } state_e;

    localparam int unsigned DefNumRegs  = 11;
    localparam int unsigned DefAddrW    = 14;
    localparam logic [7:0]  DefDataPort = 8'hBE;
    localparam logic [7:0]  DefCtrlPort = 8'hBF;
    localparam int unsigned DefIeReg    = 1;
    localparam int unsigned DefIeBit    = 5;

endpackage

// File: rtl/vdp_ctrl_port_if.sv
// Z80 I/O bus, VRAM/CRAM port and frame interrupt signals of the VDP port engine.
interface vdp_ctrl_port_if #(
    parameter int unsigned ADDR_W = 14
) ();

    logic [7:0]        addr_in;
    logic [7:0]        data_in;
    logic              IORQ_L;
    logic              RD_L;
    logic              WR_L;
    logic [7:0]        data_out;
    logic              frame_evt;
    logic              INT_L;
    logic [ADDR_W-1:0] vram_addr;
    logic              vram_we;
    logic              vram_re;
    logic [7:0]        vram_wdata;
    logic [7:0]        vram_rdata;
    logic              cram_we;

    modport master (
        output addr_in, data_in, IORQ_L, RD_L, WR_L, frame_evt, vram_rdata,
        input  data_out, INT_L, vram_addr, vram_we, vram_re, vram_wdata, cram_we
    );

    modport slave (
        input  addr_in, data_in, IORQ_L, RD_L, WR_L, frame_evt, vram_rdata,
        output data_out, INT_L, vram_addr, vram_we, vram_re, vram_wdata, cram_we
    );

endinterface

// File: rtl/vdp_reg_bank.sv
// VDP register file: indexed byte writes, packed output, out-of-range indices dropped.
module vdp_reg_bank #(
    parameter int unsigned NUM_REGS = 11
) (
    input  logic                  clk,
    input  logic                  rst_L,
    input  logic                  i_we,
    input  logic [3:0]            i_idx,
    input  logic [7:0]            i_wdata,
    output logic [NUM_REGS*8-1:0] o_regs
);

    logic [NUM_REGS*8-1:0] r_regs;

    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            r_regs <= '0;
        end else if (i_we) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                if (i_idx == 4'(i)) r_regs[i*8 +: 8] <= i_wdata;
            end
        end
    end

    assign o_regs = r_regs;

endmodule

// File: rtl/vdp_ctrl_port.sv
// Z80-facing VDP control/data port: command latch, auto-increment address,
// read-ahead buffer, status register and maskable frame interrupt.
module vdp_ctrl_port
    import vdp_pkg::*;
#(
    parameter int unsigned NUM_REGS  = DefNumRegs,
    parameter int unsigned ADDR_W    = DefAddrW,
    parameter logic [7:0]  DATA_PORT = DefDataPort,
    parameter logic [7:0]  CTRL_PORT = DefCtrlPort,
    parameter int unsigned IE_REG    = DefIeReg,
    parameter int unsigned IE_BIT    = DefIeBit
) (
    input  logic                  clk,
    input  logic                  rst_L,
    vdp_ctrl_port_if.slave        bus,
    output logic [NUM_REGS*8-1:0] regs
);

    state_e            r_state, w_state_nxt;
    logic              r_first, r_frame, r_int_n;
    logic [7:0]        r_tmp, r_buf, r_data_out, r_vram_wdata;
    code_e             r_code;
    logic [ADDR_W-1:0] r_addr;
    logic              r_vram_we, r_vram_re, r_cram_we;

    logic w_is_ctrl, w_write, w_access, w_need_fetch, w_act, w_fetch_done;
    logic w_ctrl_wr, w_ctrl_2nd, w_stat_rd, w_data_wr, w_data_rd, w_reg_we;

    assign w_is_ctrl = (bus.addr_in == CTRL_PORT);
    assign w_write   = ~bus.WR_L;
    assign w_access  = ~bus.IORQ_L & (~bus.RD_L | ~bus.WR_L)
                     & (w_is_ctrl | (bus.addr_in == DATA_PORT));
    assign w_need_fetch = (w_is_ctrl & w_write & r_first & (bus.data_in[7:6] == VRAM_RD))
                        | (~w_is_ctrl & ~w_write);

    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) r_state <= StIdle;
        else        r_state <= w_state_nxt;
    end

    // FETCH spans two cycles: the strobe cycle, then the cycle rdata is valid.
    always_comb begin
        w_state_nxt  = r_state;
        w_act        = 1'b0;
        w_fetch_done = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (w_access) begin
                    w_act       = 1'b1;
                    w_state_nxt = w_need_fetch ? StFetch : StHold;
                end
            end
            StFetch: begin
                if (!r_vram_re) begin
                    w_fetch_done = 1'b1;
                    w_state_nxt  = StHold;
                end
            end
            StHold: begin
                if (bus.IORQ_L) w_state_nxt = StIdle;
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    assign w_ctrl_wr  = w_act & w_is_ctrl & w_write;
    assign w_ctrl_2nd = w_ctrl_wr & r_first;
    assign w_stat_rd  = w_act & w_is_ctrl & ~w_write;
    assign w_data_wr  = w_act & ~w_is_ctrl & w_write;
    assign w_data_rd  = w_act & ~w_is_ctrl & ~w_write;
    assign w_reg_we   = w_ctrl_2nd & (bus.data_in[7:6] == REG_WR);

    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            r_first      <= 1'b0;
            r_frame      <= 1'b0;
            r_int_n      <= 1'b1;
            r_tmp        <= '0;
            r_buf        <= '0;
            r_data_out   <= '0;
            r_vram_wdata <= '0;
            r_code       <= VRAM_RD;
            r_addr       <= '0;
            r_vram_we    <= 1'b0;
            r_vram_re    <= 1'b0;
            r_cram_we    <= 1'b0;
        end else begin
            r_vram_we <= w_data_wr & (r_code != CRAM_WR);
            r_cram_we <= w_data_wr & (r_code == CRAM_WR);
            r_vram_re <= w_data_rd | (w_ctrl_2nd & (bus.data_in[7:6] == VRAM_RD));

            if (w_ctrl_wr) begin
                if (!r_first) begin
                    r_tmp   <= bus.data_in;
                    r_first <= 1'b1;
                end else begin
                    r_code  <= code_e'(bus.data_in[7:6]);
                    r_addr  <= ADDR_W'({bus.data_in[5:0], r_tmp});
                    r_first <= 1'b0;
                end
            end
            if (w_data_wr) begin
                r_vram_wdata <= bus.data_in;
                r_buf        <= bus.data_in;
                r_first      <= 1'b0;
            end
            if (w_data_rd) begin
                r_data_out <= r_buf;
                r_first    <= 1'b0;
            end
            if (w_stat_rd) begin
                r_data_out <= {r_frame, 7'b0};
                r_first    <= 1'b0;
            end
            if (w_fetch_done) r_buf <= bus.vram_rdata;

            // Writes bump the address after their strobe so vram_addr holds the target.
            if (w_fetch_done | r_vram_we | r_cram_we) r_addr <= r_addr + 1'b1;

            if (bus.frame_evt)   r_frame <= 1'b1;
            else if (w_stat_rd)  r_frame <= 1'b0;

            r_int_n <= ~(r_frame & regs[IE_REG*8 + IE_BIT]);
        end
    end

    vdp_reg_bank #(
        .NUM_REGS (NUM_REGS)
    ) u_reg_bank (
        .clk     (clk),
        .rst_L   (rst_L),
        .i_we    (w_reg_we),
        .i_idx   (bus.data_in[3:0]),
        .i_wdata (r_tmp),
        .o_regs  (regs)
    );

    assign bus.data_out   = r_data_out;
    assign bus.INT_L      = r_int_n;
    assign bus.vram_addr  = r_addr;
    assign bus.vram_we    = r_vram_we;
    assign bus.vram_re    = r_vram_re;
    assign bus.vram_wdata = r_vram_wdata;
    assign bus.cram_we    = r_cram_we;

endmodule

// File: tb/tb_vdp_ctrl_port.sv
// Directed, table-driven bench for vdp_ctrl_port with a behavioural VRAM.
module tb_vdp_ctrl_port;

    localparam logic [7:0] PD = 8'hBE;
    localparam logic [7:0] PC = 8'hBF;
    localparam int unsigned NR = 11;

    logic clk = 1'b0;
    logic rst_L = 1'b0;
    logic [NR*8-1:0] regs;
    logic [NR*8-1:0] exp_regs;

    vdp_ctrl_port_if #(.ADDR_W(14)) bus ();

    vdp_ctrl_port dut (
        .clk   (clk),
        .rst_L (rst_L),
        .bus   (bus),
        .regs  (regs)
    );

    always #5 clk = ~clk;

    logic [7:0]  mem [16384];
    int          we_cnt = 0, re_cnt = 0, cram_cnt = 0;
    logic [13:0] we_alog [$];
    logic [7:0]  we_dlog [$];
    logic [13:0] re_log  [$];
    logic [4:0]  cram_a = '0;
    logic [7:0]  cram_d = '0;

    always @(posedge clk) begin
        if (bus.vram_re) begin
            bus.vram_rdata <= mem[bus.vram_addr];
            re_cnt++;
            re_log.push_back(bus.vram_addr);
        end
        if (bus.vram_we) begin
            we_cnt++;
            we_alog.push_back(bus.vram_addr);
            we_dlog.push_back(bus.vram_wdata);
        end
        if (bus.cram_we) begin
            cram_cnt++;
            cram_a = bus.vram_addr[4:0];
            cram_d = bus.vram_wdata;
        end
    end

    int n_cmp = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic io_access(input logic [7:0] port, input logic wr, input logic [7:0] din);
        @(negedge clk);
        bus.addr_in = port;
        bus.data_in = din;
        bus.IORQ_L  = 1'b0;
        if (wr) bus.WR_L = 1'b0;
        else    bus.RD_L = 1'b0;
        repeat (2) @(negedge clk);
        bus.IORQ_L = 1'b1;
        bus.RD_L   = 1'b1;
        bus.WR_L   = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic frame_pulse();
        @(negedge clk);
        bus.frame_evt = 1'b1;
        @(negedge clk);
        bus.frame_evt = 1'b0;
    endtask

    typedef struct {
        logic [7:0]  port;
        logic        wr;
        logic [7:0]  din;
        logic [13:0] exp_addr;
        logic        chk_dout;
        logic [7:0]  exp_dout;
        int          exp_we;
        int          exp_re;
        int          exp_cram;
    } vec_t;

    vec_t vecs [17];

    initial begin
        bus.addr_in   = '0;
        bus.data_in   = '0;
        bus.IORQ_L    = 1'b1;
        bus.RD_L      = 1'b1;
        bus.WR_L      = 1'b1;
        bus.frame_evt = 1'b0;
        for (int i = 0; i < 16384; i++) mem[i] = 8'h00;
        mem[14'h0100] = 8'h5A;
        mem[14'h0101] = 8'h6B;
        mem[14'h0102] = 8'h7C;
        exp_regs = '0;

        vecs[0]  = '{PC, 1'b1, 8'h34, 14'h0000, 1'b0, 8'h00, 0, 0, 0};
        vecs[1]  = '{PC, 1'b1, 8'h82, 14'h0234, 1'b0, 8'h00, 0, 0, 0};
        vecs[2]  = '{PC, 1'b1, 8'h00, 14'h0234, 1'b0, 8'h00, 0, 0, 0};
        vecs[3]  = '{PC, 1'b1, 8'h7F, 14'h3F00, 1'b0, 8'h00, 0, 0, 0};
        vecs[4]  = '{PD, 1'b1, 8'hAA, 14'h3F01, 1'b0, 8'h00, 1, 0, 0};
        vecs[5]  = '{PD, 1'b1, 8'hBB, 14'h3F02, 1'b0, 8'h00, 2, 0, 0};
        vecs[6]  = '{PC, 1'b1, 8'hFF, 14'h3F02, 1'b0, 8'h00, 2, 0, 0};
        vecs[7]  = '{PC, 1'b1, 8'h7F, 14'h3FFF, 1'b0, 8'h00, 2, 0, 0};
        vecs[8]  = '{PD, 1'b1, 8'h11, 14'h0000, 1'b0, 8'h00, 3, 0, 0};
        vecs[9]  = '{PC, 1'b1, 8'h00, 14'h0000, 1'b0, 8'h00, 3, 0, 0};
        vecs[10] = '{PC, 1'b1, 8'h01, 14'h0101, 1'b0, 8'h00, 3, 1, 0};
        vecs[11] = '{PD, 1'b0, 8'h00, 14'h0102, 1'b1, 8'h5A, 3, 2, 0};
        vecs[12] = '{PD, 1'b0, 8'h00, 14'h0103, 1'b1, 8'h6B, 3, 3, 0};
        vecs[13] = '{PC, 1'b0, 8'h00, 14'h0103, 1'b1, 8'h00, 3, 3, 0};
        vecs[14] = '{PC, 1'b1, 8'h05, 14'h0103, 1'b0, 8'h00, 3, 3, 0};
        vecs[15] = '{PC, 1'b1, 8'hC0, 14'h0005, 1'b0, 8'h00, 3, 3, 0};
        vecs[16] = '{PD, 1'b1, 8'h3C, 14'h0006, 1'b0, 8'h00, 3, 3, 1};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_data_out", bus.data_out, 8'h00);
        check("rst_int_l", bus.INT_L, 1'b1);
        rst_L = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_vram_addr", bus.vram_addr, 14'h0000);
        check("rst_strobes", {bus.vram_we, bus.vram_re, bus.cram_we}, 3'b000);
        check("rst_regs", regs, exp_regs);
        check("rst_wdata", bus.vram_wdata, 8'h00);

        for (int i = 0; i < 17; i++) begin
            io_access(vecs[i].port, vecs[i].wr, vecs[i].din);
            if (i == 1) exp_regs[2*8 +: 8] = 8'h34;
            check($sformatf("vec%0d_addr", i), bus.vram_addr, vecs[i].exp_addr);
            if (vecs[i].chk_dout) check($sformatf("vec%0d_dout", i), bus.data_out, vecs[i].exp_dout);
            check($sformatf("vec%0d_counts", i), {32'(we_cnt), 32'(re_cnt), 32'(cram_cnt)},
                  {32'(vecs[i].exp_we), 32'(vecs[i].exp_re), 32'(vecs[i].exp_cram)});
        end
        check("regs_after_table", regs, exp_regs);
        check("we0", {we_alog[0], we_dlog[0]}, {14'h3F00, 8'hAA});
        check("we1", {we_alog[1], we_dlog[1]}, {14'h3F01, 8'hBB});
        check("we_wrap", {we_alog[2], we_dlog[2]}, {14'h3FFF, 8'h11});
        check("re_addrs", {re_log[0], re_log[1], re_log[2]}, {14'h0100, 14'h0101, 14'h0102});
        check("cram_write", {cram_a, cram_d}, {5'h05, 8'h3C});

        // Out-of-range register index is dropped
        io_access(PC, 1'b1, 8'h55);
        io_access(PC, 1'b1, 8'h8B);
        check("reg_oob", regs, exp_regs);

        // Frame interrupt, enabled through regs[1] bit 5
        io_access(PC, 1'b1, 8'h20);
        io_access(PC, 1'b1, 8'h81);
        exp_regs[1*8 +: 8] = 8'h20;
        check("regs_ie", regs, exp_regs);
        frame_pulse();
        check("int_l_lag", bus.INT_L, 1'b1);
        @(negedge clk);
        check("int_l_assert", bus.INT_L, 1'b0);
        io_access(PC, 1'b0, 8'h00);
        check("status_set", bus.data_out, 8'h80);
        check("int_l_cleared", bus.INT_L, 1'b1);
        io_access(PC, 1'b0, 8'h00);
        check("status_clr", bus.data_out, 8'h00);

        // Disabling the enable deasserts INT_L but keeps the flag
        frame_pulse();
        @(negedge clk);
        check("int_l_assert2", bus.INT_L, 1'b0);
        io_access(PC, 1'b1, 8'h00);
        io_access(PC, 1'b1, 8'h81);
        exp_regs[1*8 +: 8] = 8'h00;
        check("int_l_masked", bus.INT_L, 1'b1);
        io_access(PC, 1'b0, 8'h00);
        check("status_kept", bus.data_out, 8'h80);

        // frame_evt coinciding with a status-read action: set wins
        @(negedge clk);
        bus.addr_in   = PC;
        bus.IORQ_L    = 1'b0;
        bus.RD_L      = 1'b0;
        bus.frame_evt = 1'b1;
        @(negedge clk);
        bus.frame_evt = 1'b0;
        @(negedge clk);
        bus.IORQ_L = 1'b1;
        bus.RD_L   = 1'b1;
        repeat (4) @(negedge clk);
        check("coinc_old", bus.data_out, 8'h00);
        io_access(PC, 1'b0, 8'h00);
        check("coinc_flag_kept", bus.data_out, 8'h80);

        // Status read clears the half-written command latch
        io_access(PC, 1'b1, 8'h12);
        io_access(PC, 1'b0, 8'h00);
        io_access(PC, 1'b1, 8'h34);
        check("latch_no_write", regs, exp_regs);
        check("latch_no_re", 32'(re_cnt), 32'd3);
        io_access(PC, 1'b1, 8'h83);
        exp_regs[3*8 +: 8] = 8'h34;
        check("latch_tmp", regs, exp_regs);

        // Reset during an access emits no strobe
        @(negedge clk);
        bus.addr_in = PD;
        bus.data_in = 8'h99;
        bus.IORQ_L  = 1'b0;
        bus.WR_L    = 1'b0;
        rst_L       = 1'b0;
        repeat (2) @(negedge clk);
        bus.IORQ_L = 1'b1;
        bus.WR_L   = 1'b1;
        @(negedge clk);
        rst_L = 1'b1;
        repeat (3) @(negedge clk);
        check("midrst_we", 32'(we_cnt), 32'd3);
        check("midrst_state", {bus.vram_addr, bus.data_out, bus.INT_L},
              {14'h0000, 8'h00, 1'b1});
        check("midrst_regs", regs, '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
